imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory, which the core otherwise only reads.
- Accepts a framed little-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes each word to the instruction memory through a one-cycle write strobe.
- Holds the CPU in reset until a complete, valid image has been loaded, then releases it.

Parameters:
- ADDR_W, 10: instruction memory byte-address width (1024 bytes).
- MAX_WORDS, 256: largest accepted image in words; must be ≤ 2^(ADDR_W-2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte; a transfer occurs when byte_valid && byte_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  32  word-aligned byte address, equal to word_idx*4; bits [1:0] are always 0.
- imem_wdata  output  32  assembled word; first received byte maps to [7:0].
- cpu_reset  output  1  hold the core in reset; high everywhere except DONE.
- busy  output  1  load in progress (HDR_LO through WRITE, plus CSUM when the optional feature is built).
- done  output  1  level, high in DONE.
- error  output  1  level, high in ERR.

Behaviour:
- Reset is asynchronous and active-high on the single clock clk.
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, error=0. All internal counters, the length register and the byte shift register are cleared.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes.
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0. On start go to HDR_LO.
- HDR_LO: byte_ready=1. On transfer, latch LEN[7:0] and go to HDR_HI.
- HDR_HI: byte_ready=1. On transfer, latch LEN[15:8], clear word_idx and byte_cnt, then:
  - LEN==0: go to DONE; no writes occur.
  - LEN>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA: byte_ready=1. Each transfer shifts the byte into lane byte_cnt and increments the 2-bit byte_cnt. When the 4th byte of a word transfers (cycle T), go to WRITE.
- WRITE: byte_ready=0. In cycle T+1: imem_we=1, imem_addr=word_idx*4, imem_wdata=assembled word. Then word_idx increments and byte_cnt resets to 0.
  - If word_idx+1==LEN, go to DONE (or CSUM when the optional feature is built).
  - Otherwise return to DATA.
- Throughput is a maximum of 4 bytes per 5 cycles.
- DONE: cpu_reset=0, done=1. A start pulse reasserts cpu_reset on the next edge and enters HDR_LO (reload).
- ERR: error=1, cpu_reset=1. Sticky until start (go to HDR_LO) or reset. Words already written are not erased.
- start while busy is ignored.
- byte_valid while byte_ready=0 has no effect; the source must hold the byte.
- Gaps in byte_valid are legal at any point; there is no timeout.
- Reset mid-load returns the block to IDLE immediately. cpu_reset stays 1 and partially written memory contents are left untouched.
- imem_we is never high in any state other than WRITE.
- imem_addr holds its last value when imem_we is low.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds state CSUM after the last WRITE (and after HDR_HI when LEN==0).
  - In CSUM, byte_ready=1 and one trailer byte is accepted. It must equal the XOR of all data bytes (0x00 for LEN==0).
  - Match: go to DONE. Mismatch: go to ERR, with cpu_reset held high.
  - The running XOR clears on entry to HDR_LO.
- Undefined: no trailer byte, no CSUM state, and no XOR logic.

Test Plan:
1. reset pulse mid-cycle with no clock edge → all outputs at reset values immediately; cpu_reset=1.
2. start; stream 02 00 13 05 10 00 B3 85 A5 00 → imem_we pulses twice: addr 0x0 data 0x00100513, then addr 0x4 data 0x00A585B3; each pulse is 1 cycle after the 4th byte of its word; byte_ready=0 in those cycles; then done=1 and cpu_reset=0.
3. Header 01 01 (N=257 > MAX_WORDS) → error=1, cpu_reset=1, no imem_we; a new start followed by a valid frame then reaches DONE.
4. Header 00 00 → DONE with zero writes (with LOADER_CHECKSUM_EN: trailer 00 gives DONE, trailer 5A gives ERR).
5. byte_valid toggling 1,0,0,1 during DATA plus a start pulse mid-load → words assemble correctly with no loss or duplication; start is ignored.
6. Assert reset after 2 of 4 bytes of word 1 → IDLE; no imem_we for word 1; word 0 remains written in memory.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed little-endian byte stream in, 32-bit word writes out.
// Define LOADER_CHECKSUM_EN to require an XOR trailer byte after the data.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);
    // state  | meaning
    // IDLE   | out of reset, waiting for start
    // HDR_LO | receiving word count low byte
    // HDR_HI | receiving word count high byte, range check
    // DATA   | receiving the four bytes of the current word
    // WRITE  | one-cycle write strobe for the assembled word
    // CSUM   | receiving the XOR trailer byte (checksum build only)
    // DONE   | image loaded, CPU released
    // ERR    | bad length or checksum, sticky until start

    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CSUM;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      len;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [31:0]      shreg;
    logic [31:0]      addr_q;
    logic             xfer;
    logic [15:0]      hdr_len;
    logic             last_word;

    assign xfer      = byte_valid && byte_ready;
    assign hdr_len   = {byte_data, len[7:0]};
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, len};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (state_nxt == S_HDR_LO && state != S_HDR_LO) begin
            csum <= '0;
        end else if (state == S_DATA && xfer) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (xfer) state_nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (xfer) begin
                    if (hdr_len == 16'd0) begin
                        state_nxt = S_FINAL;
                    end else if (hdr_len > 16'(MAX_WORDS)) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_word ? S_FINAL : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address is captured with the last byte so it is stable for the whole WRITE cycle and holds afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                S_HDR_LO: begin
                    if (xfer) len[7:0] <= byte_data;
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        len[15:8] <= byte_data;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        shreg[{byte_cnt, 3'b000} +: 8] <= byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) addr_q <= 32'(word_idx) << 2;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + IDX_W'(1);
                    byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = state inside {S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM};
    assign busy       = state inside {S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_CSUM};
`else
    assign byte_ready = state inside {S_HDR_LO, S_HDR_HI, S_DATA};
    assign busy       = state inside {S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE};
`endif

    assign imem_we    = (state == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = shreg;
    assign cpu_reset  = (state != S_DONE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

endmodule
